// File: rtl/if_stage_hazard_pkg.sv
// Shared constants, IF/ID bundle and opcode helpers for the IF stage.
// Opcode values, IF/ID instruction field positions, NOP encoding.
package if_stage_hazard_pkg;

    localparam logic [5:0] OP_R_FORMAT = 6'h00;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SW       = 6'h2B;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_ADDI     = 6'h08;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
        logic        valid;
    } if_id_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_IMM,
        CLS_OTHER
    } instr_class_t;

    function automatic instr_class_t classify(input logic [5:0] op);
        instr_class_t cls;
        cls = CLS_OTHER;
        unique case (1'b1)
            (op == OP_R_FORMAT): cls = CLS_RTYPE;
            (op == OP_LW):       cls = CLS_LOAD;
            (op == OP_SW):       cls = CLS_STORE;
            (op == OP_BEQ),
            (op == OP_BNE):      cls = CLS_BRANCH;
            (op == OP_ADDI):     cls = CLS_IMM;
            default:             cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

    // rt is a source only for R-type, store data and branch compare.
    function automatic logic reads_rt(input instr_class_t cls);
        return (cls == CLS_RTYPE) || (cls == CLS_STORE) ||
               (cls == CLS_BRANCH);
    endfunction

    // $0 is hardwired, so a write to it can never create a hazard.
    function automatic logic hits(
        input logic [4:0] dest,
        input logic [4:0] src
    );
        return (dest != 5'd0) && (dest == src);
    endfunction

endpackage

// File: rtl/if_stage_hazard_hazard_detect.sv
// Combinational stall generation for load-use and branch operand hazards.
// Ports: IF/ID op/rs/rt/valid, ID/EX and EX/MEM writer info -> stall.
module hazard_detect
    import if_stage_hazard_pkg::*;
(
    input  logic       valid,
    input  logic [5:0] op,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       idex_MemRead,
    input  logic       idex_RegWrite,
    input  logic [4:0] idex_dest,
    input  logic       exmem_MemRead,
    input  logic [4:0] exmem_dest,
    output logic       stall
);

    instr_class_t cls;
    logic         uses_rt;
    logic         is_br;
    logic         load_use;
    logic         br_ex;
    logic         br_mem;

    always_comb begin
        cls     = classify(op);
        uses_rt = reads_rt(cls);
        is_br   = (cls == CLS_BRANCH);
    end

    // A load result is not forwardable to the very next instruction.
    always_comb begin
        load_use = idex_MemRead &&
                   (hits(idex_dest, rs) ||
                    (uses_rt && hits(idex_dest, rt)));
    end

    // Branches compare in ID, so any in-flight producer of either
    // operand one stage ahead must drain first.
    always_comb begin
        br_ex = is_br && idex_RegWrite &&
                (hits(idex_dest, rs) || hits(idex_dest, rt));
    end

    // A load two stages ahead still has no data ready for ID.
    always_comb begin
        br_mem = is_br && exmem_MemRead &&
                 (hits(exmem_dest, rs) || hits(exmem_dest, rt));
    end

    assign stall = valid && (load_use || br_ex || br_mem);

endmodule

// File: rtl/if_stage_hazard.sv
// IF stage: PC, instruction fetch, IF/ID register, stall/flush control.
// Ports: clock/reset, imem addr/data, branch redirect, hazard inputs,
//        IF/ID outputs, stall, saturating stall/flush counters.
module if_stage_hazard
    import if_stage_hazard_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_DEFAULT,
    parameter int          CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             PCSrc,
    input  logic [31:0]      branch_target,
    input  logic             idex_MemRead,
    input  logic             idex_RegWrite,
    input  logic [4:0]       idex_dest,
    input  logic             exmem_MemRead,
    input  logic [4:0]       exmem_dest,
    output logic [31:0]      IFID_instr,
    output logic [31:0]      IFID_PCplus4,
    output logic             IFID_valid,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;
    if_id_t      ifid;
    if_id_t      bubble;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        stall_sat;
    logic        flush_sat;
    logic        unused_tgt_bits;

    // Wraps mod 2^32 by construction.
    assign pc_plus4    = pc + 32'd4;
    assign redirect_pc = {branch_target[31:2], 2'b00};

    // Target is word aligned; the low bits are deliberately dropped.
    assign unused_tgt_bits = ^branch_target[1:0];

    assign bubble = '{instr: NOP_INSTR, pcplus4: 32'd0, valid: 1'b0};

    assign op = ifid.instr[OP_HI:OP_LO];
    assign rs = ifid.instr[RS_HI:RS_LO];
    assign rt = ifid.instr[RT_HI:RT_LO];

    hazard_detect u_hazard (
        .valid         (ifid.valid),
        .op            (op),
        .rs            (rs),
        .rt            (rt),
        .idex_MemRead  (idex_MemRead),
        .idex_RegWrite (idex_RegWrite),
        .idex_dest     (idex_dest),
        .exmem_MemRead (exmem_MemRead),
        .exmem_dest    (exmem_dest),
        .stall         (stall)
    );

    assign stall_sat = (stall_count == CNT_MAX);
    assign flush_sat = (flush_count == CNT_MAX);

    // Stall wins over PCSrc: the branch decision was made on stale
    // operands and will be re-evaluated once the hazard clears.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= PC_RESET;
            ifid        <= bubble;
            stall_count <= '0;
            flush_count <= '0;
        end else if (stall) begin
            if (!stall_sat) begin
                stall_count <= stall_count + 1'b1;
            end
        end else if (PCSrc) begin
            pc   <= redirect_pc;
            ifid <= bubble;
            if (!flush_sat) begin
                flush_count <= flush_count + 1'b1;
            end
        end else begin
            pc   <= pc_plus4;
            ifid <= '{instr: imem_rdata, pcplus4: pc_plus4, valid: 1'b1};
        end
    end

    assign imem_addr    = pc;
    assign IFID_instr   = ifid.instr;
    assign IFID_PCplus4 = ifid.pcplus4;
    assign IFID_valid   = ifid.valid;

endmodule

// File: tb/tb_if_stage_hazard.sv
// Testbench for if_stage_hazard: directed scenarios plus random traffic
// checked every cycle against a behavioural fetch/hazard model.
module tb_if_stage_hazard;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic          PCSrc;
    logic [31:0]   branch_target;
    logic          idex_MemRead;
    logic          idex_RegWrite;
    logic [4:0]    idex_dest;
    logic          exmem_MemRead;
    logic [4:0]    exmem_dest;
    logic [31:0]   IFID_instr;
    logic [31:0]   IFID_PCplus4;
    logic          IFID_valid;
    logic          stall;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] rom [64];

    always #5 clock = ~clock;

    if_stage_hazard #(
        .PC_RESET  (32'h0),
        .NOP_INSTR (32'h0),
        .CNT_W     (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .PCSrc         (PCSrc),
        .branch_target (branch_target),
        .idex_MemRead  (idex_MemRead),
        .idex_RegWrite (idex_RegWrite),
        .idex_dest     (idex_dest),
        .exmem_MemRead (exmem_MemRead),
        .exmem_dest    (exmem_dest),
        .IFID_instr    (IFID_instr),
        .IFID_PCplus4  (IFID_PCplus4),
        .IFID_valid    (IFID_valid),
        .stall         (stall),
        .stall_count   (stall_count),
        .flush_count   (flush_count)
    );

    function automatic logic [31:0] rom_read(input logic [31:0] a);
        if (a < 32'd256) return rom[a[7:2]];
        return 32'h2000_0000 | {16'h0, a[15:0]};
    endfunction

    always_comb imem_rdata = rom_read(imem_addr);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic model_stall(input logic [31:0] ins,
                                         input logic v);
        logic [5:0] o;
        logic [4:0] s;
        logic [4:0] t;
        logic       rt_used;
        logic       br;
        logic       lu;
        logic       bx;
        logic       bm;
        o = ins[31:26];
        s = ins[25:21];
        t = ins[20:16];
        br = (o == 6'h04) || (o == 6'h05);
        rt_used = (o == 6'h00) || (o == 6'h2B) || br;
        lu = idex_MemRead && idex_dest != 0 &&
             (idex_dest == s || (rt_used && idex_dest == t));
        bx = br && idex_RegWrite && idex_dest != 0 &&
             (idex_dest == s || idex_dest == t);
        bm = br && exmem_MemRead && exmem_dest != 0 &&
             (exmem_dest == s || exmem_dest == t);
        return v && (lu || bx || bm);
    endfunction

    // Reference model: compare at negedge, then advance using the
    // inputs that will be sampled at the coming posedge.
    initial begin
        logic        known;
        logic [31:0] m_pc;
        logic [31:0] m_ins;
        logic [31:0] m_pc4;
        logic        m_v;
        int          m_sc;
        int          m_fc;
        logic        m_st;
        known = 1'b0;
        m_pc = 0; m_ins = 0; m_pc4 = 0; m_v = 0; m_sc = 0; m_fc = 0;
        forever begin
            @(negedge clock);
            m_st = model_stall(m_ins, m_v);
            if (known) begin
                check("m_addr", imem_addr, m_pc);
                check("m_instr", IFID_instr, m_ins);
                check("m_pc4", IFID_PCplus4, m_pc4);
                check("m_valid", {31'd0, IFID_valid}, {31'd0, m_v});
                check("m_stall", {31'd0, stall}, {31'd0, m_st});
                check("m_scnt", {28'd0, stall_count}, m_sc);
                check("m_fcnt", {28'd0, flush_count}, m_fc);
            end
            if (reset) begin
                known = 1'b1;
                m_pc = 0; m_ins = 0; m_pc4 = 0; m_v = 0;
                m_sc = 0; m_fc = 0;
            end else if (m_st) begin
                if (m_sc < SAT) m_sc++;
            end else if (PCSrc) begin
                m_pc = branch_target & 32'hFFFF_FFFC;
                m_ins = 0; m_pc4 = 0; m_v = 0;
                if (m_fc < SAT) m_fc++;
            end else begin
                m_ins = rom_read(m_pc);
                m_pc = m_pc + 32'd4;
                m_pc4 = m_pc;
                m_v = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        PCSrc = 0; branch_target = 0;
        idex_MemRead = 0; idex_RegWrite = 0; idex_dest = 0;
        exmem_MemRead = 0; exmem_dest = 0;
    endtask

    initial begin
        logic [5:0] ops [6];
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B;
        ops[3] = 6'h04; ops[4] = 6'h05; ops[5] = 6'h08;
        for (int i = 0; i < 64; i++) begin
            rom[i] = {ops[$urandom_range(0, 5)],
                      5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)),
                      16'($urandom)};
        end
        rom[0]  = 32'h2008_0005;
        rom[1]  = 32'h0041_1820;
        rom[2]  = 32'h1085_0003;
        rom[16] = 32'hACC7_0000;
        idle();
        reset = 1;
        repeat (3) tick();
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'd0, IFID_valid}, 32'd0);
        check("rst_instr", IFID_instr, 32'h0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_scnt", {28'd0, stall_count}, 32'd0);
        reset = 0;
        tick();
        check("f1_instr", IFID_instr, 32'h2008_0005);
        check("f1_pc4", IFID_PCplus4, 32'd4);
        check("f1_valid", {31'd0, IFID_valid}, 32'd1);
        check("f1_addr", imem_addr, 32'd4);
        tick();
        idex_MemRead = 1; idex_dest = 2;
        #1 check("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        check("lu_hold_addr", imem_addr, 32'd8);
        check("lu_hold_instr", IFID_instr, 32'h0041_1820);
        check("lu_scnt", {28'd0, stall_count}, 32'd1);
        idle();
        tick();
        idex_MemRead = 1; idex_RegWrite = 1; idex_dest = 4;
        tick();
        idle();
        exmem_MemRead = 1; exmem_dest = 4;
        PCSrc = 1; branch_target = 32'h80;
        #1 check("br_mem_stall", {31'd0, stall}, 32'd1);
        tick();
        check("br_hold_addr", imem_addr, 32'd12);
        check("br_scnt", {28'd0, stall_count}, 32'd3);
        check("br_no_flush", {28'd0, flush_count}, 32'd0);
        idle();
        PCSrc = 1; branch_target = 32'h40;
        tick();
        check("fl_addr", imem_addr, 32'h40);
        check("fl_valid", {31'd0, IFID_valid}, 32'd0);
        check("fl_fcnt", {28'd0, flush_count}, 32'd1);
        idle();
        tick();
        idex_RegWrite = 1; idex_dest = 6;
        #1 check("sw_nobr", {31'd0, stall}, 32'd0);
        idle();
        idex_MemRead = 1; idex_dest = 7;
        #1 check("sw_rt_lu", {31'd0, stall}, 32'd1);
        idex_dest = 0;
        #1 check("r0_nohaz", {31'd0, stall}, 32'd0);
        idle();
        PCSrc = 1; branch_target = 32'hFFFF_FFFF;
        tick();
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        idle();
        tick();
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc4", IFID_PCplus4, 32'h0);
        check("wrap_instr", IFID_instr, 32'h2000_FFFC);
        tick();
        tick();
        idex_MemRead = 1; idex_dest = 1;
        repeat (20) tick();
        check("sat_scnt", {28'd0, stall_count}, SAT);
        idle();
        PCSrc = 1; branch_target = 32'h40;
        repeat (16) tick();
        check("sat_fcnt", {28'd0, flush_count}, SAT);
        idle();
        tick();
        idex_MemRead = 1; idex_dest = 7;
        #1 check("pre_rst_stall", {31'd0, stall}, 32'd1);
        reset = 1;
        tick();
        check("mr_addr", imem_addr, 32'h0);
        check("mr_valid", {31'd0, IFID_valid}, 32'd0);
        check("mr_scnt", {28'd0, stall_count}, 32'd0);
        check("mr_fcnt", {28'd0, flush_count}, 32'd0);
        reset = 0;
        idle();
        for (int k = 0; k < 400; k++) begin
            PCSrc = ($urandom_range(0, 7) == 0);
            branch_target = {24'd0, 6'($urandom_range(0, 63)),
                             2'($urandom)};
            idex_MemRead = ($urandom_range(0, 2) == 0);
            idex_RegWrite = $urandom_range(0, 1) == 1;
            idex_dest = 5'($urandom_range(0, 7));
            exmem_MemRead = ($urandom_range(0, 2) == 0);
            exmem_dest = 5'($urandom_range(0, 7));
            tick();
        end
        idle();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
